// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one source register; EX/MEM beats MEM/WB, r0 never forwarded.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_rw,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rw,
    input  logic       wb_regwrite,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_rw != REG_ZERO) && (mem_rw == src)) begin
            sel = FWD_EXMEM;
        end else if (wb_regwrite && (wb_rw != REG_ZERO) && (wb_rw == src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencing: hazards, forwarding, memory freeze, halt drain/resume, counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       ex_rw,
    input  logic [4:0]       mem_rw,
    input  logic [4:0]       wb_rw,
    input  logic             ex_regwrite,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             ex_memtoreg,
    input  logic             ex_redirect,
    input  logic             mem_halt,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             go,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             restart,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic             halted_q, restart_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             load_use, wait_now, redirect_evt, stall_evt;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    fwd_unit u_fwd_a (
        .src          (id_rs),
        .mem_rw       (mem_rw),
        .mem_regwrite (mem_regwrite),
        .wb_rw        (wb_rw),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .src          (id_rt),
        .mem_rw       (mem_rw),
        .mem_regwrite (mem_regwrite),
        .wb_rw        (wb_rw),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b_raw)
    );

    assign fwd_a = rst_n ? fwd_a_raw : FWD_REG;
    assign fwd_b = rst_n ? fwd_b_raw : FWD_REG;

    assign load_use = ex_memtoreg && ex_regwrite && (ex_rw != REG_ZERO) &&
                      ((id_use_rs && (id_rs == ex_rw)) || (id_use_rt && (id_rt == ex_rw)));
    // Once frozen, only mem_ready releases the pipeline.
    assign wait_now = (state_q == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        redirect_evt = 1'b0;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                RUN, MEM_WAIT: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    if (wait_now) begin
                        {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
                        memwb_flush = 1'b1;
                        state_d     = MEM_WAIT;
                    end else if (mem_halt) begin
                        // Squash everything younger than the halt so only it retires.
                        pc_en       = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        state_d     = DRAIN;
                        drain_d     = 3'd0;
                    end else begin
                        state_d = RUN;
                        if (ex_redirect) begin
                            ifid_flush   = 1'b1;
                            idex_flush   = 1'b1;
                            redirect_evt = 1'b1;
                        end else if (load_use) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end
                        if (restart_q) ifid_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    if (drain_q == DRAIN_LAST) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q + 3'd1;
                    end
                end
                HALTED: begin
                    if (go) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign stall_evt = ((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_q     <= 3'd0;
            halted_q    <= 1'b0;
            restart_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            halted_q  <= (state_d == HALTED);
            restart_q <= (state_q == HALTED) && go;
            if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (redirect_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign halted    = halted_q;
    assign restart   = restart_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; a second CNT_W=4 instance checks saturation.
module tb_pipe_ctrl;

    logic clk, rst_n;
    logic [4:0] id_rs, id_rt, ex_rw, mem_rw, wb_rw;
    logic id_use_rs, id_use_rt, ex_regwrite, mem_regwrite, wb_regwrite;
    logic ex_memtoreg, ex_redirect, mem_halt, mem_req, mem_ready, go;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic restart, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic s_restart, s_halted;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    int n_chk = 0;
    int n_fail = 0;

    wire [4:0] en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    wire [3:0] fl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};

    pipe_ctrl #(.CNT_W(16), .DRAIN_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rw(ex_rw), .mem_rw(mem_rw),
        .wb_rw(wb_rw), .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .ex_memtoreg(ex_memtoreg), .ex_redirect(ex_redirect),
        .mem_halt(mem_halt), .mem_req(mem_req), .mem_ready(mem_ready), .go(go),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .restart(restart), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4), .DRAIN_CYCLES(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rw(ex_rw), .mem_rw(mem_rw),
        .wb_rw(wb_rw), .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .ex_memtoreg(ex_memtoreg), .ex_redirect(ex_redirect),
        .mem_halt(mem_halt), .mem_req(mem_req), .mem_ready(mem_ready), .go(go),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .fwd_a(s_fwd_a),
        .fwd_b(s_fwd_b), .restart(s_restart), .halted(s_halted), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 1 ns later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {id_rs, id_rt, ex_rw, mem_rw, wb_rw} = '0;
        {id_use_rs, id_use_rt, ex_regwrite, mem_regwrite, wb_regwrite} = '0;
        {ex_memtoreg, ex_redirect, mem_halt, mem_req, mem_ready, go} = '0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        id_rs = 5'd7; mem_rw = 5'd7; wb_rw = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #2;
        chk("rst_en", 32'(en), 32'h00);
        chk("rst_fl", 32'(fl), 32'h0);
        chk("rst_fwd_a", 32'(fwd_a), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_restart", 32'(restart), 32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        chk("rst_flushc", 32'(flush_cnt), 32'h0);

        // Reset release and forwarding priority
        nxt(); rst_n = 1'b1; #1;
        chk("rel_en", 32'(en), 32'h1f);
        chk("fwd_exmem_wins", 32'(fwd_a), 32'h1);
        mem_regwrite = 1'b0; id_rt = 5'd7; #1;
        chk("fwd_a_memwb", 32'(fwd_a), 32'h2);
        chk("fwd_b_memwb", 32'(fwd_b), 32'h2);
        id_rs = 5'd0; id_rt = 5'd0; mem_rw = 5'd0; wb_rw = 5'd0; mem_regwrite = 1'b1; #1;
        chk("fwd_r0", 32'(fwd_a), 32'h0);
        clear_inputs();

        // Load-use on rs
        nxt(); ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rw = 5'd5; id_rs = 5'd5;
        id_use_rs = 1'b1; #1;
        chk("lu_en", 32'(en), 32'h07);
        chk("lu_fl", 32'(fl), 32'h4);
        nxt(); clear_inputs(); mem_rw = 5'd5; mem_regwrite = 1'b1; id_rs = 5'd5; #1;
        chk("lu_stall1", 32'(stall_cnt), 32'd1);
        chk("lu_one_cycle", 32'(en), 32'h1f);
        chk("lu_fwd_next", 32'(fwd_a), 32'h1);
        // rt match, but rt not read: no hazard
        clear_inputs(); ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rw = 5'd6; id_rt = 5'd6; #1;
        chk("lu_rt_unused", 32'(en), 32'h1f);
        nxt(); id_use_rt = 1'b1; #1;
        chk("lu_rt_en", 32'(en), 32'h07);
        nxt(); ex_rw = 5'd0; id_rt = 5'd0; #1;
        chk("lu_r0_en", 32'(en), 32'h1f);
        chk("lu_stall2", 32'(stall_cnt), 32'd2);

        // Redirect drops simultaneous load-use
        nxt(); ex_rw = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1; ex_redirect = 1'b1; #1;
        chk("rd_en", 32'(en), 32'h1f);
        chk("rd_fl", 32'(fl), 32'hc);
        nxt(); clear_inputs(); #1;
        chk("rd_flushc", 32'(flush_cnt), 32'd1);
        chk("rd_stall_same", 32'(stall_cnt), 32'd2);

        // Memory wait, three cycles
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) nxt();
            #1;
            chk("mw_en", 32'(en), 32'h01);
            chk("mw_fl", 32'(fl), 32'h1);
        end
        nxt(); mem_ready = 1'b1; #1;
        chk("mw_ready_en", 32'(en), 32'h1f);
        chk("mw_stall", 32'(stall_cnt), 32'd5);
        nxt(); mem_req = 1'b0; mem_ready = 1'b0; #1;
        chk("mw_back_run", 32'(en), 32'h1f);

        // Halt, drain two cycles, resume
        nxt(); mem_halt = 1'b1; #1;
        chk("h_det_en", 32'(en), 32'h0f);
        chk("h_det_fl", 32'(fl), 32'he);
        for (int i = 0; i < 2; i++) begin
            nxt(); mem_halt = 1'b0; #1;
            chk("dr_en", 32'(en), 32'h0f);
            chk("dr_fl", 32'(fl), 32'he);
            chk("dr_halted", 32'(halted), 32'h0);
        end
        nxt(); ex_redirect = 1'b1; #1;
        chk("ht_halted", 32'(halted), 32'h1);
        chk("ht_en", 32'(en), 32'h00);
        chk("ht_fl", 32'(fl), 32'h0);
        for (int i = 0; i < 4; i++) nxt();
        ex_redirect = 1'b0; go = 1'b1; #1;
        chk("ht_still", 32'(halted), 32'h1);
        chk("ht_stall", 32'(stall_cnt), 32'd6);
        chk("ht_flushc", 32'(flush_cnt), 32'd1);
        nxt(); go = 1'b0; #1;
        chk("rs_restart", 32'(restart), 32'h1);
        chk("rs_halted", 32'(halted), 32'h0);
        chk("rs_en", 32'(en), 32'h1f);
        chk("rs_fl", 32'(fl), 32'h8);
        nxt(); #1;
        chk("rs_pulse_end", 32'(restart), 32'h0);
        chk("rs_fl_end", 32'(fl), 32'h0);

        // Reset while HALTED
        mem_halt = 1'b1;
        nxt(); mem_halt = 1'b0;
        nxt(); nxt(); nxt(); #1;
        chk("h2_halted", 32'(halted), 32'h1);
        #2; rst_n = 1'b0; #1;
        chk("ar_halted", 32'(halted), 32'h0);
        chk("ar_en", 32'(en), 32'h00);
        nxt(); rst_n = 1'b1; #1;
        chk("ar_rel_en", 32'(en), 32'h1f);
        nxt(); #1;
        chk("ar_no_restart", 32'(restart), 32'h0);
        chk("ar_run_en", 32'(en), 32'h1f);

        // Continuous stalls: 16-bit counts on, 4-bit saturates at 15
        ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_rw = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
        for (int i = 0; i < 20; i++) nxt();
        #1;
        chk("sat_wide", 32'(stall_cnt), 32'd20);
        chk("sat_narrow", 32'(s_stall_cnt), 32'd15);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
